// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: PC register, next-PC select and IF/ID register with stall/flush/redirect and sticky halt.
// Optional DELAY_SLOT_EN: accepted redirects keep the delay-slot instruction in IF/ID.
module fetch_pipe_ctrl #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_WORD  = 32'h0000_0000,
    parameter logic [31:0]     HALT_WORD = 32'hFFFF_FFFF,
    parameter int              MAX_STALL = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            PCWrite,
    input  logic            IFIDWrite,
    input  logic            IFIDFlush,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump_taken,
    input  logic [PC_W-1:0] jump_target,
    input  logic [31:0]     imem_data,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instr_IFID,
    output logic [PC_W-1:0] pc4_IFID,
    output logic            valid_IFID,
    output logic            halted,
    output logic [3:0]      stall_cnt,
    output logic            stall_timeout
);
    typedef enum logic [1:0] {RUN, STALL, HALT} fsmState;

    fsmState         state, stateNext;
    logic [PC_W-1:0] pcPlus4, pcNext;
    logic            squash;
    logic [3:0]      stallNext;

    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_comb begin
        pcPlus4   = pc + PC_W'(4);
`ifdef DELAY_SLOT_EN
        squash    = IFIDFlush;
`else
        squash    = IFIDFlush || (!halted && PCWrite && (jump_taken || branch_taken));
`endif
        pcNext    = (halted || !PCWrite) ? pc :
                    jump_taken ? jump_target :
                    branch_taken ? branch_target : pcPlus4;
        stallNext = halted ? stall_cnt :
                    PCWrite ? 4'd0 :
                    (stall_cnt == 4'hF) ? stall_cnt : stall_cnt + 4'd1;
        stateNext = halted ? HALT :
                    (valid_IFID && instr_IFID == HALT_WORD) ? HALT :
                    PCWrite ? RUN : STALL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            instr_IFID    <= NOP_WORD;
            pc4_IFID      <= '0;
            valid_IFID    <= 1'b0;
            stall_cnt     <= 4'd0;
            stall_timeout <= 1'b0;
        end else begin
            state         <= stateNext;
            pc            <= pcNext;
            stall_cnt     <= stallNext;
            stall_timeout <= (stallNext >= 4'(MAX_STALL));
            // halt bubbles IF/ID but leaves pc4 as last loaded
            if (halted) begin
                instr_IFID <= NOP_WORD;
                valid_IFID <= 1'b0;
            end else if (IFIDWrite) begin
                instr_IFID <= squash ? NOP_WORD : imem_data;
                valid_IFID <= !squash;
                pc4_IFID   <= pcPlus4;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// tb_fetch_pipe_ctrl: directed and randomized checks of fetch_pipe_ctrl against a behavioural model.
module tb_fetch_pipe_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        PCWrite, IFIDWrite, IFIDFlush, branch_taken, jump_taken;
    logic [31:0] branch_target, jump_target, imem_data, imem_addr, pc, instr_IFID, pc4_IFID;
    logic        valid_IFID, halted, stall_timeout;
    logic [3:0]  stall_cnt;
    logic [31:0] haltAddr = 32'hDEAD_0000;

    logic [31:0] mPc, mInstr, mPc4;
    bit          mValid, mHalt;
    int          mStall;
    int          total = 0, bad = 0;

    fetch_pipe_ctrl dut (
        .clk(clk), .reset_n(reset_n), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDFlush(IFIDFlush), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_taken(jump_taken), .jump_target(jump_target), .imem_data(imem_data),
        .imem_addr(imem_addr), .pc(pc), .instr_IFID(instr_IFID), .pc4_IFID(pc4_IFID),
        .valid_IFID(valid_IFID), .halted(halted), .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordAt(input logic [31:0] a, input logic [31:0] h);
        return (a == h) ? 32'hFFFF_FFFF : {a[15:0], ~a[15:0]};
    endfunction

    assign imem_data = wordAt(imem_addr, haltAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compareAll();
        check("pc", pc, mPc);
        check("imem_addr", imem_addr, mPc);
        check("instr_IFID", instr_IFID, mInstr);
        check("pc4_IFID", pc4_IFID, mPc4);
        check("valid_IFID", 32'(valid_IFID), 32'(mValid));
        check("halted", 32'(halted), 32'(mHalt));
        check("stall_cnt", 32'(stall_cnt), 32'(mStall));
        check("stall_timeout", 32'(stall_timeout), 32'(mStall >= 15));
    endtask

    task automatic setIn(input bit pcw, input bit ifw, input bit fl, input bit bt,
                         input logic [31:0] bTgt, input bit jt, input logic [31:0] jTgt);
        PCWrite = pcw; IFIDWrite = ifw; IFIDFlush = fl;
        branch_taken = bt; branch_target = bTgt; jump_taken = jt; jump_target = jTgt;
    endtask

    task automatic idle();
        setIn(1, 1, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        #1;
        mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 0; mHalt = 0; mStall = 0;
        compareAll();
        #1 reset_n = 1'b1;
    endtask

    // one clock edge of the reference behaviour, then compare
    task automatic tick();
        logic [31:0] nPc, nInstr, nPc4;
        bit          nValid, nHalt, accepted;
        accepted = !mHalt && PCWrite && (jump_taken || branch_taken);
        nPc = (mHalt || !PCWrite) ? mPc : jump_taken ? jump_target : branch_taken ? branch_target : mPc + 32'd4;
        nInstr = mInstr; nPc4 = mPc4; nValid = mValid;
        if (mHalt) begin
            nInstr = 32'h0; nValid = 0;
        end else if (IFIDWrite) begin
            nPc4 = mPc + 32'd4;
`ifdef DELAY_SLOT_EN
            accepted = 0;
`endif
            if (IFIDFlush || accepted) begin
                nInstr = 32'h0; nValid = 0;
            end else begin
                nInstr = wordAt(mPc, haltAddr); nValid = 1;
            end
        end
        nHalt = mHalt || (mValid && mInstr == 32'hFFFF_FFFF);
        if (!mHalt) mStall = PCWrite ? 0 : (mStall < 15 ? mStall + 1 : 15);
        mPc = nPc; mInstr = nInstr; mPc4 = nPc4; mValid = nValid; mHalt = nHalt;
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #2 doReset();
        repeat (3) tick();
        check("pc_after3", pc, 32'hC);
        check("instr_after3", instr_IFID, wordAt(32'h8, haltAddr));
        tick();
        setIn(0, 0, 0, 0, 32'h0, 0, 32'h0);
        tick();
        check("stall_pc_hold", pc, 32'h10);
        check("stall_cnt_one", 32'(stall_cnt), 32'd1);
        idle();
        repeat (4) tick();
        setIn(1, 1, 0, 1, 32'h40, 0, 32'h0);
        tick();
        check("branch_pc", pc, 32'h40);
`ifdef DELAY_SLOT_EN
        check("branch_slot", instr_IFID, wordAt(32'h20, haltAddr));
`else
        check("branch_squash", instr_IFID, 32'h0);
`endif
        setIn(1, 1, 0, 1, 32'h40, 1, 32'h80);
        tick();
        check("jump_wins", pc, 32'h80);
        setIn(0, 1, 0, 1, 32'h40, 1, 32'h100);
        tick();
        check("redirect_stalled", pc, 32'h80);
        setIn(1, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        tick();
        idle();
        tick();
        check("pc_wrap", pc, 32'h0);

        haltAddr = 32'h14;
        doReset();
        repeat (7) tick();
        check("halt_raised", 32'(halted), 32'd1);
        for (int i = 0; i < 8; i++) begin
            setIn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1, 32'h40, 1'($urandom_range(0, 1)), 32'h80);
            tick();
        end
        check("halt_pc_frozen", pc, 32'h1C);
        check("halt_nop", instr_IFID, 32'h0);

        haltAddr = 32'hDEAD_0000;
        doReset();
        setIn(0, 0, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("timeout_low14", 32'(stall_timeout), 32'd0);
            if (i == 15) begin
                check("timeout_rise15", 32'(stall_timeout), 32'd1);
                check("stall_cnt15", 32'(stall_cnt), 32'd15);
            end
        end
        #3 doReset();

        for (int b = 0; b < 4; b++) begin
            haltAddr = (b == 2) ? 32'h30 : 32'hDEAD_0000;
            doReset();
            for (int i = 0; i < 150; i++) begin
                setIn($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 63) * 4,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 63) * 4);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
